// File: rtl/pkt_fifo_pkg.sv
// Shared constants for the packet FIFO: MPEG-TS packet geometry and the
// default build parameters used by pkt_fifo.
package pkt_fifo_pkg;

  localparam int         TS_PKT_LEN     = 188;
  localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
  localparam int DEF_AFULL      = DEF_DEPTH - TS_PKT_LEN;

endpackage

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port storage for pkt_fifo: synchronous write, read data
// registered only when a read is accepted. The array itself has no reset;
// only the read-data register is cleared so rdata is 0 in reset.
module pkt_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read-data register: loads on an accepted read, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO with speculative write side: words become visible to the
// reader only once the packet is committed; a drop rewinds the write
// pointer to the last commit point.
// Optional feature: define PKT_FIFO_DROP_CNT_EN to add the drop_cnt port
// (saturating count of effective packet drops).
//
// Handshake: a write is accepted on a clock edge when wen && !wfull; a read
// is accepted when ren && !rempty and its data appears on rdata after that
// edge. Requests made while the flag blocks them have no effect on data
// (a blocked write additionally poisons the current packet).
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - TS_PKT_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wcommit,
  input  logic                  wdrop,
  output logic                  wfull,
  output logic                  wafull,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rcnt
`ifdef PKT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Pointers carry one extra bit so full (diff == DEPTH) and empty
  // (diff == 0) are distinct; all differences wrap modulo 2**PTR_W.
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] cptr_q, cptr_d;
  logic [PTR_W-1:0] sptr_q, sptr_d;
  logic             ovf_q, ovf_d;

  logic [PTR_W-1:0] spec_occ;
  logic [PTR_W-1:0] sptr_inc;
  logic             we, re, ovf_set, eff_drop, eff_commit;

  // Flags decoded straight from the registered pointers.
  assign spec_occ = sptr_q - rptr_q;
  assign rcnt     = cptr_q - rptr_q;
  assign rempty   = (cptr_q == rptr_q);
  assign wfull    = (spec_occ == PTR_W'(DEPTH));
  assign wafull   = (spec_occ >= PTR_W'(AFULL_THRESH));

  assign we       = wen && !wfull;
  assign re       = ren && !rempty;
  assign ovf_set  = wen && wfull;
  assign sptr_inc = sptr_q + {{(PTR_W-1){1'b0}}, we};

  // A packet that lost a word to overflow (earlier, or on this very edge)
  // cannot be published; its commit turns into a drop. Drop beats commit.
  assign eff_drop   = wdrop || (wcommit && (ovf_q || ovf_set));
  assign eff_commit = wcommit && !eff_drop;

  // Next-state for pointers and the overflow flag.
  always_comb begin
    rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, re};
    sptr_d = eff_drop   ? cptr_q   : sptr_inc;
    cptr_d = eff_commit ? sptr_inc : cptr_q;
    ovf_d  = ovf_q || ovf_set;
    if (wcommit || wdrop) ovf_d = 1'b0;
  end

  // Pointer and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      cptr_q <= '0;
      sptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
      sptr_q <= sptr_d;
      ovf_q  <= ovf_d;
    end
  end

  pkt_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (we),
    .wr_addr_i (sptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wdata),
    .rd_en_i   (re),
    .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rdata)
  );

`ifdef PKT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Count only drops that actually discard something; saturate at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (eff_drop && ((sptr_q != cptr_q) || ovf_q) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: queue-based packet model updated on each clock edge,
// one compare process on the falling edge, plus directed packet scenarios
// with literal expectations.
module tb_pkt_fifo;
  import pkt_fifo_pkg::*;

  localparam int DEPTH = 512;
  localparam int AFULL = DEPTH - 188;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0, wcommit = 1'b0, wdrop = 1'b0, ren = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wfull, wafull, rempty;
  logic [7:0] rdata;
  logic [9:0] rcnt;
`ifdef PKT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  pkt_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (wen),
    .wdata   (wdata),
    .wcommit (wcommit),
    .wdrop   (wdrop),
    .wfull   (wfull),
    .wafull  (wafull),
    .ren     (ren),
    .rdata   (rdata),
    .rempty  (rempty),
    .rcnt    (rcnt)
`ifdef PKT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cq: committed, unread bytes.  pq: bytes of the open packet.
  logic [7:0] cq[$];
  logic [7:0] pq[$];
  logic [7:0] m_rdata = 8'h00;
  bit         m_ovf = 1'b0;
  int         m_drops = 0;
  int         m_occ;
  bit         m_full, m_had_pend, m_ovf_set, m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq.delete();
      pq.delete();
      m_rdata = 8'h00;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_occ      = cq.size() + pq.size();
      m_full     = (m_occ == DEPTH);
      m_had_pend = (pq.size() != 0);
      if (ren && cq.size() != 0) m_rdata = cq.pop_front();
      if (wen && !m_full) pq.push_back(wdata);
      m_ovf_set = wen && m_full;
      m_drop    = wdrop || (wcommit && (m_ovf || m_ovf_set));
      if (m_drop) begin
        if ((m_had_pend || m_ovf) && m_drops < 65535) m_drops++;
        pq.delete();
      end else if (wcommit) begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
      end
      if (wcommit || wdrop) m_ovf = 1'b0;
      else                  m_ovf = m_ovf || m_ovf_set;
    end
  end

  // ---------------- compare process ----------------
  int c_occ;
  always @(negedge clk) begin
    c_occ = cq.size() + pq.size();
    check("rdata",  int'(rdata),  int'(m_rdata));
    check("rempty", int'(rempty), int'(cq.size() == 0));
    check("rcnt",   int'(rcnt),   cq.size());
    check("wfull",  int'(wfull),  int'(c_occ == DEPTH));
    check("wafull", int'(wafull), int'(c_occ >= AFULL));
`ifdef PKT_FIFO_DROP_CNT_EN
    check("drop_cnt", int'(drop_cnt), m_drops);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit w, input logic [7:0] d, input bit c,
                      input bit dr, input bit r);
    wen = w; wdata = d; wcommit = c; wdrop = dr; ren = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] pkt_byte(input int k, input int seed);
    return (k == 0) ? TS_SYNC_BYTE : 8'(k - 1 + seed);
  endfunction

  task automatic write_pkt(input int n, input int seed, input bit commit_last,
                           input bit rd);
    for (int k = 0; k < n; k++)
      step(1'b1, pkt_byte(k, seed), commit_last && (k == n - 1), 1'b0, rd);
  endtask

  task automatic idle(input int n, input bit rd);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, rd);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    @(negedge clk);
    check("rst_rempty", int'(rempty), 1);
    check("rst_rcnt",   int'(rcnt),   0);
    check("rst_rdata",  int'(rdata),  0);
    idle(1, 1'b0);
    #1 rst_n = 1'b1;
    idle(1, 1'b0);

    // Uncommitted packet stays invisible, then is dropped.
    write_pkt(188, 0, 1'b0, 1'b0);
    check("nocommit_rempty", int'(rempty), 1);
    check("nocommit_rcnt",   int'(rcnt),   0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Commit on last byte; read back in order with 1-cycle latency.
    write_pkt(188, 0, 1'b1, 1'b0);
    check("commit_rcnt",   int'(rcnt),   188);
    check("commit_rempty", int'(rempty), 0);
    for (int k = 0; k < 188; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("inorder_rdata", int'(rdata), int'(pkt_byte(k, 0)));
    end
    check("drained_rempty", int'(rempty), 1);

    // Partial packet dropped, next packet committed.
    write_pkt(100, 40, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    write_pkt(188, 3, 1'b1, 1'b0);
    check("afterdrop_rcnt", int'(rcnt), 188);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("afterdrop_first", int'(rdata), 8'h47);
`ifdef PKT_FIFO_DROP_CNT_EN
    check("drop_cnt_2", int'(drop_cnt), 2);
`endif
    idle(187, 1'b1);

    // Overflow: 376 committed, 140 more writes, commit is forced to drop.
    write_pkt(188, 1, 1'b1, 1'b0);
    write_pkt(188, 2, 1'b1, 1'b0);
    check("two_pkt_rcnt",  int'(rcnt),   376);
    check("two_pkt_afull", int'(wafull), 1);
    for (int k = 0; k < 136; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
    check("full_at_512", int'(wfull), 1);
    for (int k = 0; k < 4; k++) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("ovf_rcnt",  int'(rcnt),  376);
    check("ovf_wfull", int'(wfull), 0);
`ifdef PKT_FIFO_DROP_CNT_EN
    check("drop_cnt_3", int'(drop_cnt), 3);
`endif
    idle(377, 1'b1);

    // Commit and drop together: drop wins.
    write_pkt(50, 7, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("both_rcnt",   int'(rcnt),   0);
    check("both_rempty", int'(rempty), 1);

    // Long stream with concurrent read/write across many pointer wraps.
    for (int i = 0; i < 10000; i++)
      step(1'b1, 8'(i * 7 + 3), (i % 188) == 187, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset in the middle of a packet with committed data present.
    write_pkt(188, 5, 1'b1, 1'b0);
    write_pkt(60, 6, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    idle(3, 1'b0);
    check("inrst_rempty", int'(rempty), 1);
    check("inrst_rcnt",   int'(rcnt),   0);
    check("inrst_rdata",  int'(rdata),  0);
    check("inrst_wfull",  int'(wfull),  0);
    check("inrst_wafull", int'(wafull), 0);
`ifdef PKT_FIFO_DROP_CNT_EN
    check("inrst_drop_cnt", int'(drop_cnt), 0);
`endif
    #1 rst_n = 1'b1;
    idle(1, 1'b0);
    write_pkt(188, 9, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("postrst_first", int'(rdata), 8'h47);
    check("postrst_rcnt",  int'(rcnt),  187);
    idle(190, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_fifo.md
PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the word width.
REQ-003 Parameter ADDR_WIDTH, default 9, SHALL set DEPTH = 2**ADDR_WIDTH (512 words, at least two 188-byte TS packets).
REQ-004 Parameter AFULL_THRESH, default DEPTH-188, SHALL set the almost-full level in words.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- wen  in  1  write request.
- wdata  in  DATA_WIDTH  write word.
- wcommit  in  1  publish the current packet to the read side.
- wdrop  in  1  discard the current uncommitted packet.
- wfull  out  1  speculative occupancy == DEPTH.
- wafull  out  1  speculative occupancy >= AFULL_THRESH.
- ren  in  1  read request.
- rdata  out  DATA_WIDTH  read word.
- rempty  out  1  committed occupancy == 0.
- rcnt  out  ADDR_WIDTH+1  committed occupancy.
- drop_cnt  out  16  dropped-packet count (macro only, REQ-022).

Function
REQ-006 Pointers SHALL be ADDR_WIDTH+1 bits: rptr, cptr (committed write) and sptr (speculative write); full and empty are distinguished by the MSB.
REQ-007 An accepted write, we = wen && !wfull, SHALL store wdata at sptr[ADDR_WIDTH-1:0] and increment sptr.
REQ-008 A read is accepted when re = ren && !rempty; it SHALL load mem[rptr] into rdata on the same edge (1-cycle latency) and increment rptr; rdata SHALL hold its value otherwise.
REQ-009 On wcommit, cptr SHALL take the updated sptr, including a word accepted in the same cycle.
REQ-010 On wdrop, sptr SHALL return to cptr, and a word written in the same cycle SHALL be discarded.
REQ-011 If wcommit and wdrop are both asserted, wdrop SHALL win.
REQ-012 wen while wfull SHALL set a sticky ovf flag; a subsequent wcommit with ovf set SHALL behave as wdrop; ovf SHALL clear on any commit or drop.
REQ-013 Occupancy SHALL be computed modulo 2**(ADDR_WIDTH+1):
- rcnt = cptr - rptr.
- Speculative occupancy = sptr - rptr.
REQ-014 rempty, rcnt, wfull and wafull SHALL be decoded from registered pointers, so they reflect the state after each edge with no extra lag.
REQ-015 The read side SHALL never observe uncommitted words.
REQ-016 A read and a write/commit in the same cycle SHALL both take effect; rempty deasserts the cycle after a commit.
REQ-017 Pointer wrap-around SHALL be seamless across the DEPTH boundary.

Reset
REQ-018 While rst_n is low:
- rptr, cptr, sptr and ovf = 0.
- rdata = 0, rempty = 1, wfull = 0, wafull = 0, rcnt = 0, drop_cnt = 0.
REQ-019 Reset mid-packet SHALL discard all committed and uncommitted data; there is no memory clear.

Configuration
REQ-020 Macro PKT_FIFO_DROP_CNT_EN SHALL control the drop counter.
REQ-021 With the macro defined, drop_cnt SHALL increment (saturating at 16'hFFFF) on each effective drop (wdrop, or overflow-forced commit), but only when sptr != cptr or ovf is set.
REQ-022 Without the macro, the drop_cnt port and its logic SHALL be absent.

Structure
REQ-023 Package pkt_fifo_pkg SHALL hold TS_PKT_LEN = 188, TS_SYNC_BYTE = 8'h47 and the default parameter constants.
REQ-024 Storage SHALL be a sub-module pkt_fifo_mem: simple dual-port, synchronous write, registered read enable, no reset on the array.

Verification
REQ-025 Write 188 bytes 0x47,0x00..; no commit: rempty stays 1 and rcnt = 0.
REQ-026 Write 188 bytes with wcommit on the last wen: next cycle rcnt = 188 and rempty = 0; 188 reads return the bytes in order, each 1 cycle after ren.
REQ-027 Write 100 bytes, then wdrop; write 188 and commit: rcnt = 188 and the first read returns the second packet's 0x47; drop_cnt = 1 with the macro.
REQ-028 With DEPTH = 512, commit 2 packets (376), then write 140 more: wfull asserts at 512 speculative words, extra wen sets ovf, and the following wcommit drops the packet so rcnt stays 376.
REQ-029 Assert wcommit and wdrop together after 50 writes: the packet is dropped and rcnt is unchanged.
REQ-030 Stream 10,000 bytes with simultaneous ren/wen across pointer wrap, then pulse rst_n low mid-packet: data stays in order with no loss, and all outputs match their reset values during reset.
